display_scroller: RTL and testbench

DISPLAY_SCROLLER -- requirements
Module: display_scroller

---
 rtl/display_scroller.sv | 170 +++++++++++++++++
 tb/tb_display_scroller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : display_scroller
//  Description : Scrolls a 16-digit hex message through an eight-digit
//                display window. A 16 x 4-bit message buffer is written
//                through a simple write port. While running, the window
//                start index (pos) advances by one digit every STEP_DIV
//                clocks, in either direction. The scroll runs endlessly or
//                stops after one full revolution.
//  Ports       : ck               - clock, rising edge
//                rst              - asynchronous active-high reset
//                wr_en/addr/data  - message buffer write port
//                start/stop       - start/restart and abort scrolling
//                dir              - 0: pos increments, 1: pos decrements
//                loop             - 1: endless, 0: one revolution
//                busy/done        - running flag / end-of-revolution pulse
//                pos              - current window start index
//                seg0..seg7       - digit codes mem[(pos+k) mod 16]
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scroller #(
    parameter int STEP_DIV = 50000000
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       loop,
    output logic       busy,
    output logic       done,
    output logic [3:0] pos,
    output logic [3:0] seg0,
    output logic [3:0] seg1,
    output logic [3:0] seg2,
    output logic [3:0] seg3,
    output logic [3:0] seg4,
    output logic [3:0] seg5,
    output logic [3:0] seg6,
    output logic [3:0] seg7
);

    localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div;
    logic [3:0]       step_cnt;
    logic [3:0]       mem [16];

    // Datapath controls produced by the FSM.
    logic clear;   // zero divider and step counter
    logic count;   // advance the divider this cycle
    logic step;    // divider wraps: move pos, bump step counter

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and datapath controls. stop has priority over start,
    // and start in RUN restarts the revolution without issuing a step.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        count     = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    clear = 1'b1;
                end else begin
                    count = 1'b1;
                    if (div == DIV_LAST) begin
                        step = 1'b1;
                        // Sixteenth step of a one-shot returns pos to its start.
                        if (!loop && (step_cnt == 4'd15)) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Divider, step counter and window position
    // ------------------------------------------------------------------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            div      <= '0;
            step_cnt <= 4'd0;
            pos      <= 4'd0;
        end else if (clear) begin
            div      <= '0;
            step_cnt <= 4'd0;
        end else if (count) begin
            if (step) begin
                div      <= '0;
                step_cnt <= step_cnt + 4'd1;
                pos      <= dir ? (pos - 4'd1) : (pos + 4'd1);
            end else begin
                div <= div + DIV_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Message buffer: writable in any state, cleared by reset
    // ------------------------------------------------------------------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 4'd0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The 4-bit index sums wrap modulo 16 on their own.
    // ------------------------------------------------------------------------
    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign seg0 = mem[pos];
    assign seg1 = mem[pos + 4'd1];
    assign seg2 = mem[pos + 4'd2];
    assign seg3 = mem[pos + 4'd3];
    assign seg4 = mem[pos + 4'd4];
    assign seg5 = mem[pos + 4'd5];
    assign seg6 = mem[pos + 4'd6];
    assign seg7 = mem[pos + 4'd7];

endmodule
`default_nettype wire

// File: tb/tb_display_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scroller
//  Description : Self-checking bench for display_scroller (STEP_DIV = 4).
//                A behavioural model tracks elapsed run cycles and completed
//                steps; outputs are compared every cycle on the falling edge.
//                Directed sequences pin the model with literal values, then
//                a randomized phase and an asynchronous reset finish the run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scroller;

    localparam int STEP_DIV = 4;

    logic       ck;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       stop;
    logic       dir;
    logic       loop;
    logic       busy;
    logic       done;
    logic [3:0] pos;
    logic [3:0] seg [8];

    int checks;
    int errors;

    // Model: mode 0 = idle, 1 = scrolling, 2 = end-of-revolution pulse.
    int m_mode;
    int m_pos;
    int m_elapsed;
    int m_steps;
    int m_mem [16];

    display_scroller #(.STEP_DIV(STEP_DIV)) dut (
        .ck      (ck),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .loop    (loop),
        .busy    (busy),
        .done    (done),
        .pos     (pos),
        .seg0    (seg[0]),
        .seg1    (seg[1]),
        .seg2    (seg[2]),
        .seg3    (seg[3]),
        .seg4    (seg[4]),
        .seg5    (seg[5]),
        .seg6    (seg[6]),
        .seg7    (seg[7])
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_pos     = 0;
        m_elapsed = 0;
        m_steps   = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
    endtask

    // Apply one rising edge worth of behaviour using the inputs in force.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (m_mode == 2) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (start && !stop) begin
                    m_mode    = 1;
                    m_elapsed = 0;
                    m_steps   = 0;
                end
            end else begin
                if (stop) begin
                    m_mode = 0;
                end else if (start) begin
                    m_elapsed = 0;
                    m_steps   = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed % STEP_DIV == 0) begin
                        m_pos = dir ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
                        m_steps++;
                        if (!loop && (m_steps % 16 == 0)) m_mode = 2;
                    end
                end
            end
            if (wr_en) m_mem[wr_addr] = int'(wr_data);
        end
    endtask

    task automatic compare_all();
        check("busy", int'(busy), (m_mode == 1) ? 1 : 0);
        check("done", int'(done), (m_mode == 2) ? 1 : 0);
        check("pos", int'(pos), m_pos);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("seg%0d", k), int'(seg[k]), m_mem[(m_pos + k) % 16]);
        end
    endtask

    // One clock: model follows the rising edge, outputs checked on falling.
    task automatic cycle();
        @(posedge ck);
        model_edge();
        @(negedge ck);
        compare_all();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 4'd0;
        start   = 1'b0;
        stop    = 1'b0;
        dir     = 1'b0;
        loop    = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_pos", int'(pos), 0);
        check("rst_seg0", int'(seg[0]), 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Load mem[i] = i, no start
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 4'(i);
            cycle();
        end
        wr_en = 1'b0;
        cycle();
        for (int k = 0; k < 8; k++) check("load_seg", int'(seg[k]), k);
        check("load_pos", int'(pos), 0);
        check("load_busy", int'(busy), 0);

        // One-shot revolution, incrementing
        dir   = 1'b0;
        loop  = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("os_busy", int'(busy), 1);
        for (int s = 1; s <= 16; s++) begin
            repeat (STEP_DIV) cycle();
            check("os_pos", int'(pos), s % 16);
        end
        check("os_done", int'(done), 1);
        cycle();
        check("os_idle_busy", int'(busy), 0);
        check("os_idle_done", int'(done), 0);

        // Endless, decrementing from pos 0
        dir   = 1'b1;
        loop  = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (STEP_DIV) cycle();
        check("dn_pos", int'(pos), 15);
        for (int k = 0; k < 8; k++) check("dn_seg", int'(seg[k]), (k + 15) % 16);
        repeat (20 * STEP_DIV) cycle();
        check("dn_still_busy", int'(busy), 1);
        check("dn_pos21", int'(pos), 11);

        // stop, then start+stop in IDLE, then start+stop with divider at 3
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_idle", int'(busy), 0);
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        check("both_idle", int'(busy), 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (STEP_DIV - 1) cycle();
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        check("both_run_busy", int'(busy), 0);
        check("both_run_pos", int'(pos), 11);

        // Write mem[pos+3] during RUN
        dir   = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        wr_en   = 1'b1;
        wr_addr = 4'((m_pos + 3) % 16);
        wr_data = 4'hA;
        cycle();
        wr_en = 1'b0;
        check("wr_seg3", int'(seg[3]), 10);
        repeat (2) cycle();
        check("wr_step_pos", int'(pos), 12);
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            start   = ($urandom_range(0, 149) == 0);
            stop    = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            if ($urandom_range(0, 59) == 0) loop = ~loop;
            rst     = ($urandom_range(0, 799) == 0);
            cycle();
        end
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        cycle();

        // Asynchronous reset mid-RUN
        dir   = 1'b0;
        loop  = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        check("pre_arst_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_pos", int'(pos), 0);
        for (int k = 0; k < 8; k++) check("arst_seg", int'(seg[k]), 0);
        model_reset();
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 4'd9;
        cycle();
        cycle();
        wr_en = 1'b0;
        rst   = 1'b0;
        repeat (8) cycle();
        check("post_arst_busy", int'(busy), 0);
        check("post_arst_seg5", int'(seg[5]), 0);
        check("post_arst_pos", int'(pos), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
